// File: rtl/fpconv_pkg.sv
// Shared types and constants for the fixed-to-float sequential converter.
package fpconv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  function automatic int exp_load(input int in_w, input int mant_w);
    return in_w - 1 - mant_w;
  endfunction

  // Counter must hold exp_load+1 and everything up to the largest exponent.
  function automatic int cnt_width(input int in_w, input int exp_w,
                                   input int mant_w);
    int a;
    a = $clog2(in_w - mant_w + 1);
    return ((a > exp_w) ? a : exp_w) + 1;
  endfunction

endpackage

// File: rtl/fpconv_round.sv
// Round/saturate stage of the converter; pure combinational.
// Rounding is enabled by defining FPCONV_ROUND_EN, otherwise truncates.
module fpconv_round
  import fpconv_pkg::*;
#(
  parameter int EXP_W  = 3,
  parameter int MANT_W = 4,
  parameter int CNT_W  = 5
) (
  input  logic [MANT_W-1:0] f_raw,
  input  logic              r,
  input  logic [CNT_W-1:0]  exp_cnt,
  input  logic              sat_in,
  output logic [EXP_W-1:0]  e,
  output logic [MANT_W-1:0] f,
  output logic              sat
);

`ifdef FPCONV_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] E_MAX = CNT_W'((1 << EXP_W) - 1);

  logic              inc;
  logic [MANT_W:0]   f_sum;
  logic [MANT_W-1:0] f_rnd;
  logic [CNT_W-1:0]  e_adj;

  assign inc   = r & ROUND_EN;
  assign f_sum = {1'b0, f_raw} + {{MANT_W{1'b0}}, inc};

  always_comb begin
    f_rnd = f_sum[MANT_W-1:0];
    e_adj = exp_cnt;
    if (f_sum[MANT_W]) begin
      f_rnd = {1'b1, {(MANT_W-1){1'b0}}};
      e_adj = exp_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    e   = e_adj[EXP_W-1:0];
    f   = f_rnd;
    sat = 1'b0;
    if (sat_in || (e_adj > E_MAX)) begin
      e   = '1;
      f   = '1;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/fp_converter_seq.sv
// Sequential two's-complement to sign/exponent/significand converter.
// Define FPCONV_ROUND_EN for round-half-up; default build truncates.
module fp_converter_seq
  import fpconv_pkg::*;
#(
  parameter int IN_W   = 12,
  parameter int EXP_W  = 3,
  parameter int MANT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_s,
  output logic [EXP_W-1:0]  out_e,
  output logic [MANT_W-1:0] out_f,
  output logic              out_sat
);

  localparam int CNT_W = cnt_width(IN_W, EXP_W, MANT_W);
  localparam logic [CNT_W-1:0] E_LOAD = CNT_W'(exp_load(IN_W, MANT_W));
  localparam int R_IDX = IN_W - 2 - MANT_W;

  state_t state, state_nxt;

  // Magnitude top bit only feeds the saturate flag, so it is not stored.
  logic [IN_W-2:0]   mag, mag_nxt;
  logic [CNT_W-1:0]  exp_cnt, exp_nxt;
  logic              sign, sign_nxt;
  logic              sat_flag, sat_flag_nxt;
  logic              valid_nxt, s_nxt, sat_nxt;
  logic [EXP_W-1:0]  e_nxt;
  logic [MANT_W-1:0] f_nxt;

  logic [IN_W-1:0]   abs_val;
  logic              r_bit;
  logic [EXP_W-1:0]  rnd_e;
  logic [MANT_W-1:0] rnd_f;
  logic              rnd_sat;

  assign abs_val  = in_data[IN_W-1] ? -in_data : in_data;
  assign in_ready = (state == IDLE);

  generate
    if (R_IDX >= 0) begin : g_rbit
      assign r_bit = mag[R_IDX];
    end else begin : g_nobit
      assign r_bit = 1'b0;
    end
  endgenerate

  fpconv_round #(
    .EXP_W  (EXP_W),
    .MANT_W (MANT_W),
    .CNT_W  (CNT_W)
  ) u_round (
    .f_raw   (mag[IN_W-2 -: MANT_W]),
    .r       (r_bit),
    .exp_cnt (exp_cnt),
    .sat_in  (sat_flag),
    .e       (rnd_e),
    .f       (rnd_f),
    .sat     (rnd_sat)
  );

  always_comb begin
    state_nxt    = state;
    mag_nxt      = mag;
    exp_nxt      = exp_cnt;
    sign_nxt     = sign;
    sat_flag_nxt = sat_flag;
    valid_nxt    = out_valid;
    s_nxt        = out_s;
    e_nxt        = out_e;
    f_nxt        = out_f;
    sat_nxt      = out_sat;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          sign_nxt     = in_data[IN_W-1];
          mag_nxt      = abs_val[IN_W-2:0];
          sat_flag_nxt = abs_val[IN_W-1];
          exp_nxt      = E_LOAD;
          state_nxt    = NORM;
        end
      end
      NORM: begin
        if (mag[IN_W-2] || (exp_cnt == '0)) begin
          state_nxt = ROUND;
        end else begin
          mag_nxt = mag << 1;
          exp_nxt = exp_cnt - CNT_W'(1);
        end
      end
      ROUND: begin
        s_nxt     = sign;
        e_nxt     = rnd_e;
        f_nxt     = rnd_f;
        sat_nxt   = rnd_sat;
        valid_nxt = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mag       <= '0;
      exp_cnt   <= '0;
      sign      <= 1'b0;
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_e     <= '0;
      out_f     <= '0;
      out_sat   <= 1'b0;
    end else begin
      state     <= state_nxt;
      mag       <= mag_nxt;
      exp_cnt   <= exp_nxt;
      sign      <= sign_nxt;
      sat_flag  <= sat_flag_nxt;
      out_valid <= valid_nxt;
      out_s     <= s_nxt;
      out_e     <= e_nxt;
      out_f     <= f_nxt;
      out_sat   <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_fp_converter_seq.sv
// Randomized and directed bench for fp_converter_seq (default parameters).
// Expected values follow FPCONV_ROUND_EN the same way the design does.
module tb_fp_converter_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [2:0]  out_e;
  logic [3:0]  out_f;
  logic        out_sat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_converter_seq #(
    .IN_W   (12),
    .EXP_W  (3),
    .MANT_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_sat   (out_sat)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // value ~= f * 2^e, with e the smallest exponent that fits f in 4 bits
  task automatic model(input logic [11:0] din, output int s, output int e,
                       output int f, output int sat, output int lat);
    int v, mag, p, r;
    v   = int'($signed(din));
    s   = int'(din[11]);
    mag = (v < 0) ? -v : v;
    if (mag >= 2048) begin
      e = 7; f = 15; sat = 1; lat = 9;
      return;
    end
    p = -1;
    for (int i = 0; i < 12; i++)
      if (mag >= (1 << i)) p = i;
    e   = (p > 3) ? p - 3 : 0;
    lat = (7 - e) + 2;
    f   = mag >> e;
    r   = (e > 0) ? ((mag >> (e - 1)) & 1) : 0;
`ifdef FPCONV_ROUND_EN
    f = f + r;
    if (f == 16) begin
      f = 8;
      e = e + 1;
    end
`endif
    sat = 0;
    if (e > 7) begin
      e = 7; f = 15; sat = 1;
    end
  endtask

  task automatic check_fields(input string tag, input int s, input int e,
                              input int f, input int sat);
    check({tag, ".s"}, 32'(out_s), s);
    check({tag, ".e"}, 32'(out_e), e);
    check({tag, ".f"}, 32'(out_f), f);
    check({tag, ".sat"}, 32'(out_sat), sat);
  endtask

  task automatic convert(input logic [11:0] din, input int hold,
                         input string tag);
    int s, e, f, sat, lat, cyc, w;
    model(din, s, e, f, sat, lat);
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".ready"}, 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = din;
    @(posedge clk);
    #1;
    // keep in_valid up with junk data: must be ignored while busy
    in_data = 12'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, ".lat"}, 32'(cyc), lat);
    check_fields(tag, s, e, f, sat);
    check({tag, ".busy"}, 32'(in_ready), 0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_v"}, 32'(out_valid), 1);
      check({tag, ".hold_rdy"}, 32'(in_ready), 0);
      check_fields({tag, ".hold"}, s, e, f, sat);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".drop_v"}, 32'(out_valid), 0);
    check({tag, ".idle"}, 32'(in_ready), 1);
    check_fields({tag, ".after"}, s, e, f, sat);
  endtask

  logic [11:0] dir_vals [6];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    dir_vals  = '{12'd422, 12'd46, 12'd248, 12'hE5A, 12'h7FF, 12'h800};

    repeat (2) @(posedge clk);
    #1;
    check("rst.v", 32'(out_valid), 0);
    check_fields("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst.ready", 32'(in_ready), 1);

    foreach (dir_vals[i])
      convert(dir_vals[i], i % 3, $sformatf("dir%0d", i));

    // reset in the middle of a long conversion
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 12'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst.v", 32'(out_valid), 0);
    check_fields("midrst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst.ready", 32'(in_ready), 1);
    check("midrst.v2", 32'(out_valid), 0);
    convert(12'd422, 1, "postrst");

    convert(12'd0, 5, "zero");

    for (int n = 0; n < 40; n++)
      convert(12'($urandom), int'($urandom_range(0, 2)),
              $sformatf("rnd%0d", n));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
